// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Package     : watch_pkg
// Description : Shared types, BCD limits and BCD increment/validity helpers
//               for the watch time-setting controller.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

  // Setter controller states; COMMIT lasts exactly one cycle.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EDIT_HOUR = 2'd1,
    S_EDIT_MIN  = 2'd2,
    S_COMMIT    = 2'd3
  } setter_state_t;

  localparam logic [3:0] HOUR_TENS_MAX       = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX        = 4'd5;
  localparam logic [3:0] DIGIT_MAX           = 4'd9;

  // True when tens:units is a BCD hour in 00..23.
  function automatic logic bcd_hour_valid(input logic [3:0] tens, input logic [3:0] units);
    logic ok;
    ok = (tens <= DIGIT_MAX) && (units <= DIGIT_MAX) &&
         ((tens < HOUR_TENS_MAX) ||
          ((tens == HOUR_TENS_MAX) && (units <= HOUR_UNITS_MAX_AT_2)));
    return ok;
  endfunction

  // True when tens:units is a BCD minute in 00..59.
  function automatic logic bcd_min_valid(input logic [3:0] tens, input logic [3:0] units);
    return (tens <= MIN_TENS_MAX) && (units <= DIGIT_MAX);
  endfunction

  // Hours step 09->10, 19->20, 23->00; input is {tens, units}.
  function automatic logic [7:0] bcd_hour_inc(input logic [7:0] hh);
    logic [7:0] r;
    if ((hh[7:4] == HOUR_TENS_MAX) && (hh[3:0] == HOUR_UNITS_MAX_AT_2)) begin
      r = 8'h00;
    end else if (hh[3:0] == DIGIT_MAX) begin
      r = {hh[7:4] + 4'd1, 4'd0};
    end else begin
      r = {hh[7:4], hh[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Minutes step with units carry into tens, 59->00; input is {tens, units}.
  function automatic logic [7:0] bcd_min_inc(input logic [7:0] mm);
    logic [7:0] r;
    if (mm[3:0] == DIGIT_MAX) begin
      r = (mm[7:4] == MIN_TENS_MAX) ? 8'h00 : {mm[7:4] + 4'd1, 4'd0};
    end else begin
      r = {mm[7:4], mm[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-FF synchronizer, stable-count debouncer and one-cycle
//               press pulse on each debounced 0->1.
// Ports       : clk, rstn (async active-low)
//               btn_i   raw asynchronous button
//               level_o debounced level
//               press_o one-cycle pulse, coincident with level_o rising
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any cycle where the synced value agrees with the level restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/watch_time_setter.sv
`default_nettype none
// ============================================================================
// Module      : watch_time_setter
// Description : Button-driven hour/minute editor producing the watch's BCD
//               init digits and a one-cycle load strobe.
// Ports       : clk, rstn (async active-low)
//               btn_mode, btn_inc      raw buttons
//               *_now                  current watch time (BCD digits)
//               *_init                 edited time (BCD digits, registered)
//               load                   one-cycle commit strobe
//               editing, edit_sel      edit status (0 idle, 1 hours, 2 minutes)
// Revision    : 1.0 - initial release
// ============================================================================
module watch_time_setter
  import watch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 2_000_000,
  parameter int unsigned REPEAT_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       load,
  output logic       editing,
  output logic [1:0] edit_sel
);

  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic mode_press;
  logic mode_level_unused;
  logic inc_press;
  logic inc_level;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_mode),
    .level_o (mode_level_unused),
    .press_o (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
    .clk     (clk),
    .rstn    (rstn),
    .btn_i   (btn_inc),
    .level_o (inc_level),
    .press_o (inc_press)
  );

  setter_state_t state_q;
  logic [3:0]    hd_q, ho_q, md_q, mo_q;
  logic          load_q;
  logic          editing_q;
  logic [1:0]    edit_sel_q;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] to_q;

  logic       in_edit;
  logic       rep_hit;
  logic       inc_evt;
  logic [7:0] hour_inc_d;
  logic [7:0] min_inc_d;

  always_comb begin
    in_edit    = (state_q == S_EDIT_HOUR) || (state_q == S_EDIT_MIN);
    rep_hit    = in_edit && inc_level && (rep_q == RW'(REPEAT_CYCLES - 1));
    // MODE has priority: an INC landing in the same cycle is dropped.
    inc_evt    = in_edit && !mode_press && (inc_press || rep_hit);
    // Repeat phase is anchored on the press and on each repeat.
    rep_d      = (!in_edit || !inc_level || inc_press || rep_hit) ? '0 : rep_q + 1'b1;
    hour_inc_d = bcd_hour_inc({hd_q, ho_q});
    min_inc_d  = bcd_min_inc({md_q, mo_q});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hd_q       <= '0;
      ho_q       <= '0;
      md_q       <= '0;
      mo_q       <= '0;
      load_q     <= 1'b0;
      editing_q  <= 1'b0;
      edit_sel_q <= 2'd0;
      rep_q      <= '0;
      to_q       <= '0;
    end else begin
      rep_q  <= rep_d;
      load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mode_press) begin
            state_q    <= S_EDIT_HOUR;
            editing_q  <= 1'b1;
            edit_sel_q <= 2'd1;
            to_q       <= '0;
            // Out-of-range or non-BCD fields start the edit from 00.
            if (bcd_hour_valid(hourdec_now, hourone_now)) begin
              hd_q <= hourdec_now;
              ho_q <= hourone_now;
            end else begin
              hd_q <= '0;
              ho_q <= '0;
            end
            if (bcd_min_valid(mindec_now, minone_now)) begin
              md_q <= mindec_now;
              mo_q <= minone_now;
            end else begin
              md_q <= '0;
              mo_q <= '0;
            end
          end
        end
        S_EDIT_HOUR, S_EDIT_MIN: begin
          if (mode_press) begin
            to_q <= '0;
            if (state_q == S_EDIT_HOUR) begin
              state_q    <= S_EDIT_MIN;
              edit_sel_q <= 2'd2;
            end else begin
              state_q    <= S_COMMIT;
              load_q     <= 1'b1;
              editing_q  <= 1'b0;
              edit_sel_q <= 2'd0;
            end
          end else if (inc_evt) begin
            to_q <= '0;
            if (state_q == S_EDIT_HOUR) begin
              {hd_q, ho_q} <= hour_inc_d;
            end else begin
              {md_q, mo_q} <= min_inc_d;
            end
          end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon without load; edited digits stay on *_init.
            state_q    <= S_IDLE;
            editing_q  <= 1'b0;
            edit_sel_q <= 2'd0;
            to_q       <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          editing_q  <= 1'b0;
          edit_sel_q <= 2'd0;
        end
      endcase
    end
  end

  assign hourdec_init = hd_q;
  assign hourone_init = ho_q;
  assign mindec_init  = md_q;
  assign minone_init  = mo_q;
  assign load         = load_q;
  assign editing      = editing_q;
  assign edit_sel     = edit_sel_q;

endmodule
`default_nettype wire
